reg_dump_uart_tx: RTL and testbench
===================================

// Module: reg_dump_uart_tx
// PURPOSE
//  Reads the register file's debug port on request and streams all 32 registers out over a UART TX line (8N1).
//  Drives debug_reg_addr and consumes debug_reg_data, so a host PC can capture full CPU register state on the FPGA board.
//  Byte sequence: sync byte 0xA5, then x0..x31, each 4 bytes MSB first (129 bytes total).
// PARAMETERS
//  CLKS_PER_BIT  868   clock cycles per UART bit (100 MHz / 115200); legal range >= 2
//  NUM_REGS      32    registers dumped, starting at x0; legal range 1..32
//  SYNC_BYTE     8'hA5 first byte of every dump
// PORTS
//  clk             in   1   system clock; all logic on rising edge
//  rst             in   1   asynchronous active-low reset
//  dump_start      in   1   single-cycle request to begin a dump
//  debug_reg_addr  out  5   register index presented to the register-file debug port
//  debug_reg_data  in   32  combinational read data for debug_reg_addr (same cycle)
//  uart_tx         out  1   serial output; idle high
//  busy            out  1   high while a dump is in progress
//  done            out  1   one-cycle pulse when the last stop bit completes
// BEHAVIOUR
//  Reset (rst=0, async): uart_tx=1, busy=0, done=0, debug_reg_addr=0, FSM=IDLE, all counters 0.
//  FSM: IDLE -> SYNC -> ADDR -> CAPTURE -> SEND(x4) -> ADDR ... -> FINISH -> IDLE.
//   IDLE: dump_start=1 -> SYNC; busy goes high the next cycle.
//   SYNC: hand SYNC_BYTE to the serializer; after its frame -> ADDR with reg index 0.
//   ADDR: drive debug_reg_addr=index for one cycle (settle cycle).
//   CAPTURE: latch debug_reg_data into a 32-bit shadow; byte counter=3.
//   SEND: issue shadow[8*k+7:8*k] for k=3..0; each byte waits for serializer ready.
//   After byte 0: if index==NUM_REGS-1 -> FINISH, else index+1 -> ADDR.
//   FINISH: done=1 for one cycle, busy=0 in the same cycle -> IDLE.
//  Frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
//  The next frame's start bit follows the previous stop bit with at most 3 cycles of idle-high gap.
//  dump_start while busy=1: ignored, never queued.
//  Register values are sampled per register at CAPTURE; the dump is not an atomic snapshot of all registers.
//  x0 is dumped as read (0 from the register file); no special-casing here.
//  Reset mid-frame: uart_tx returns to 1 immediately; no partial byte is resumed after reset.
//  Baud counter width is $clog2(CLKS_PER_BIT); it wraps to 0 at CLKS_PER_BIT-1.
//  debug_reg_addr holds its last value between dumps; it is 0 only after reset.
// STRUCTURE
//  Shared package (tiny_rv_dbg_pkg): SYNC_BYTE default, UART frame constants (START_BIT=0, STOP_BIT=1, DATA_BITS=8),
//   FSM state encoding localparams.
//  Sub-module uart_tx_byte: byte serializer with a valid/ready input handshake.
//   Ports: clk, rst, data[7:0], valid, ready, tx. ready=1 only when idle.
//   A byte is accepted on the cycle valid&&ready.
//  Top level keeps the FSM, register index, byte counter and 32-bit shadow.
// TESTING
//  Use CLKS_PER_BIT=4; a UART monitor decodes uart_tx. The bench models the register file, combinational from debug_reg_addr.
//  1 Reset, uart_tx sampled 100 cycles -> constant 1; busy=0, done=0, debug_reg_addr=0.
//  2 x1=32'hDEADBEEF, x31=32'h01234567, others 0; pulse dump_start ->
//    monitor gets A5, 00 00 00 00, DE AD BE EF, ..., 01 23 45 67 (129 bytes); exactly one done pulse.
//  3 Bit timing: every bit of every frame lasts exactly 4 cycles; start-to-start spacing is 40..43 cycles.
//    Total busy time is between 129*40 and 129*43 cycles.
//  4 dump_start pulsed again mid-dump (byte 50) -> byte stream unchanged, still 129 bytes, one done.
//  5 rst asserted during a data bit of byte 10 -> uart_tx=1 the same cycle, busy=0.
//    A new dump_start after release produces a full, correct 129-byte dump.
//  6 NUM_REGS=1, x0 only -> bytes A5 00 00 00 00; done follows the last stop bit; back-to-back dumps both correct.

Source files
------------

// File: rtl/tiny_rv_dbg_pkg.sv
// Shared constants for the register-dump debug path: sync byte, UART 8N1
// frame layout, dump FSM state encoding and a byte-select helper.
package tiny_rv_dbg_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = DATA_BITS + 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_ADDR    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SEND    = 3'd4,
    ST_FINISH  = 3'd5
  } dump_state_e;

  // Byte idx of a 32-bit word (idx 3 = most significant byte).
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A byte is accepted when valid && ready; ready is high
// only while no frame is in flight. The frame is shifted out of a register
// whose bit 0 drives the line, so tx is always a flop output and idles high.
module uart_tx_byte
  import tiny_rv_dbg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int                 CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]      BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]         LAST_BIT  = 4'(FRAME_BITS - 1);
  localparam logic [FRAME_BITS-1:0] IDLE_FRAME = {FRAME_BITS{STOP_BIT}};

  logic                  active_q, active_d;
  logic [CW-1:0]         baud_q,   baud_d;
  logic [3:0]            bit_q,    bit_d;
  logic [FRAME_BITS-1:0] frame_q,  frame_d;

  // State registers; reset forces the line high at once, dropping any partial frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= 4'd0;
      frame_q  <= IDLE_FRAME;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
    end
  end

  // Accept a byte when idle, otherwise time each bit and shift in stop-level ones.
  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    if (!active_q) begin
      if (valid) begin
        active_d = 1'b1;
        baud_d   = '0;
        bit_d    = 4'd0;
        frame_d  = {STOP_BIT, data, START_BIT};
      end else begin
        frame_d  = IDLE_FRAME;
      end
    end else if (baud_q == BAUD_LAST) begin
      baud_d = '0;
      if (bit_q == LAST_BIT) begin
        active_d = 1'b0;
        frame_d  = IDLE_FRAME;
      end else begin
        bit_d   = bit_q + 4'd1;
        frame_d = {STOP_BIT, frame_q[FRAME_BITS-1:1]};
      end
    end else begin
      baud_d = baud_q + CW'(1);
    end
  end

  assign ready = !active_q;
  assign tx    = frame_q[0];

endmodule

// File: rtl/reg_dump_uart_tx.sv
// Register-file dump over UART: on dump_start, sends the sync byte and then
// NUM_REGS registers (x0 upwards), each as 4 bytes MSB first. Each register is
// read through the debug port with one settle cycle before it is latched.
module reg_dump_uart_tx
  import tiny_rv_dbg_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         NUM_REGS     = 32,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dump_start,
  output logic [4:0]  debug_reg_addr,
  input  logic [31:0] debug_reg_data,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  dump_state_e state_q, state_d;
  logic [4:0]  idx_q,    idx_d;
  logic [1:0]  cnt_q,    cnt_d;
  logic [31:0] shadow_q, shadow_d;

  logic        ser_valid;
  logic        ser_ready;
  logic [7:0]  ser_data;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk  (clk),
    .rst  (rst),
    .data (ser_data),
    .valid(ser_valid),
    .ready(ser_ready),
    .tx   (uart_tx)
  );

  // FSM state, register index, byte counter and captured register word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= 5'd0;
      cnt_q    <= 2'd0;
      shadow_q <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  // Next-state logic; dump_start is only looked at in IDLE so requests while busy vanish.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (dump_start) state_d = ST_SYNC;
        else            state_d = ST_IDLE;
      end
      ST_SYNC: begin
        if (ser_ready) begin
          state_d = ST_ADDR;
          idx_d   = 5'd0;
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_ADDR: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        shadow_d = debug_reg_data;
        cnt_d    = 2'd3;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (ser_ready) begin
          if (cnt_q == 2'd0) begin
            if (idx_q == LAST_IDX) begin
              state_d = ST_FINISH;
            end else begin
              idx_d   = idx_q + 5'd1;
              state_d = ST_ADDR;
            end
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_FINISH: begin
        if (ser_ready) state_d = ST_IDLE;
        else           state_d = ST_FINISH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Serializer request, status flags; done marks the end of the final stop bit.
  always_comb begin
    ser_valid = 1'b0;
    ser_data  = 8'h00;
    done      = 1'b0;
    case (state_q)
      ST_SYNC: begin
        ser_valid = 1'b1;
        ser_data  = SYNC_BYTE;
      end
      ST_SEND: begin
        ser_valid = 1'b1;
        ser_data  = byte_sel(shadow_q, cnt_q);
      end
      ST_FINISH: begin
        done = ser_ready;
      end
      default: begin
        ser_valid = 1'b0;
      end
    endcase
    busy = (state_q != ST_IDLE) && !done;
  end

  assign debug_reg_addr = idx_q;

endmodule

// File: tb/tb_reg_dump_uart_tx.sv
// Bench for reg_dump_uart_tx: a UART monitor decodes the line and checks bit
// timing, each decoded byte is compared against a queue of expected bytes
// filled from the bench's own register-file model when a dump is requested.
module tb_reg_dump_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [4:0]  addr_a, addr_b;
  logic [31:0] data_a, data_b;
  logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;

  logic [31:0] regs [32];
  logic        sel = 1'b0;
  logic        mon_tx;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [7:0]  exp_q [$];
  int          bytes_rx = 0;
  int          mon_bit = -1;
  bit          prev_ok = 1'b0;
  int          prev_t = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign data_a = regs[addr_a];
  assign data_b = regs[addr_b];
  assign mon_tx = sel ? tx_b : tx_a;

  reg_dump_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_REGS(32)) dut_a (
    .clk(clk), .rst(rst), .dump_start(start_a), .debug_reg_addr(addr_a),
    .debug_reg_data(data_a), .uart_tx(tx_a), .busy(busy_a), .done(done_a)
  );

  reg_dump_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_REGS(1)) dut_b (
    .clk(clk), .rst(rst), .dump_start(start_b), .debug_reg_addr(addr_b),
    .debug_reg_data(data_b), .uart_tx(tx_b), .busy(busy_b), .done(done_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_dump(input int nregs);
    exp_q.push_back(8'hA5);
    for (int r = 0; r < nregs; r++)
      for (int k = 3; k >= 0; k--)
        exp_q.push_back(regs[r][8*k +: 8]);
  endtask

  // UART monitor: samples on falling edges, so each bit shows as CPB equal samples.
  initial begin : monitor
    int         t0;
    int         bad;
    bit         ab;
    logic [7:0] rx;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && mon_tx === 1'b0) begin
        t0 = cyc; bad = 0; ab = 1'b0; rx = 8'h00;
        if (prev_ok)
          check_eq("start_spacing", 32'((t0 - prev_t >= 40) && (t0 - prev_t <= 43)), 32'd1);
        prev_t  = t0;
        prev_ok = 1'b1;
        for (int b = 0; b < 10; b++) begin
          for (int s = 0; s < CPB; s++) begin
            if (!(b == 0 && s == 0)) @(negedge clk);
            mon_bit = b;
            if (rst !== 1'b1) ab = 1'b1;
            if (!ab) begin
              if (b == 0) begin
                if (mon_tx !== 1'b0) bad++;
              end else if (b == 9) begin
                if (mon_tx !== 1'b1) bad++;
              end else if (s == 0) begin
                rx[b-1] = mon_tx;
              end else if (mon_tx !== rx[b-1]) begin
                bad++;
              end
            end
          end
        end
        mon_bit = -1;
        if (ab) begin
          prev_ok = 1'b0;
        end else begin
          check_eq("frame_bit_timing", 32'(bad), 32'd0);
          if (exp_q.size() == 0) check_eq("unexpected_byte_qsize", 32'(exp_q.size()), 32'd1);
          else check_eq("rx_byte", {24'h0, rx}, {24'h0, exp_q.pop_front()});
          bytes_rx++;
        end
      end
    end
  end

  task automatic run_dump(input bit use_b, input int nregs, input int mid_byte);
    int base;
    int nb;
    int busy_cyc = 0;
    int dones = 0;
    int t = 0;
    bit fin = 1'b0;
    bit pulsed = 1'b0;
    sel     = use_b;
    prev_ok = 1'b0;
    push_dump(nregs);
    nb   = 1 + 4 * nregs;
    base = bytes_rx;
    @(negedge clk);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    while (!fin && t < 8000) begin
      if (use_b ? busy_b : busy_a) busy_cyc++;
      if (use_b ? done_b : done_a) begin dones++; fin = 1'b1; end
      if (mid_byte > 0 && !pulsed && bytes_rx == base + mid_byte) begin
        pulsed = 1'b1;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
      end
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      t++;
    end
    repeat (20) begin
      if (use_b ? done_b : done_a) dones++;
      @(negedge clk);
    end
    check_eq("done_seen", 32'(fin), 32'd1);
    check_eq("done_count", 32'(dones), 32'd1);
    check_eq("byte_count", 32'(bytes_rx - base), 32'(nb));
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    check_eq("busy_time_in_range", 32'((busy_cyc >= nb * 40) && (busy_cyc <= nb * 43)), 32'd1);
    check_eq("busy_low_after", 32'(use_b ? busy_b : busy_a), 32'd0);
    check_eq("addr_holds_last", 32'(use_b ? addr_b : addr_a), 32'(nregs - 1));
    if (mid_byte > 0) check_eq("mid_start_issued", 32'(pulsed), 32'd1);
  endtask

  initial begin : main
    int bad_idle;
    int base;
    int t;
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;

    // Reset state and idle line.
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx_a), 32'd1);
    rst = 1'b1;
    bad_idle = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || tx_b !== 1'b1) bad_idle++;
    end
    check_eq("idle_tx_high", 32'(bad_idle), 32'd0);
    check_eq("idle_busy", 32'(busy_a), 32'd0);
    check_eq("idle_done", 32'(done_a), 32'd0);
    check_eq("idle_addr", 32'(addr_a), 32'd0);

    // Full dump with two non-zero registers, then a dump with a request mid-way.
    regs[1]  = 32'hDEADBEEF;
    regs[31] = 32'h01234567;
    run_dump(1'b0, 32, 0);
    regs[5] = 32'hCAFE_F00D;
    run_dump(1'b0, 32, 50);

    // Reset during a data bit of byte 10, then a clean dump.
    sel = 1'b0; prev_ok = 1'b0;
    push_dump(32);
    base = bytes_rx;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    t = 0;
    while (!(bytes_rx == base + 10 && mon_bit >= 2 && mon_bit <= 7) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check_eq("rst_point_reached", 32'(t < 3000), 32'd1);
    check_eq("tx_low_before_rst", 32'(tx_a), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("rst_mid_tx", 32'(tx_a), 32'd1);
    check_eq("rst_mid_busy", 32'(busy_a), 32'd0);
    exp_q.delete();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    check_eq("post_rst_addr", 32'(addr_a), 32'd0);
    check_eq("post_rst_tx", 32'(tx_a), 32'd1);
    run_dump(1'b0, 32, 0);

    // Single-register instance, two dumps back to back.
    run_dump(1'b1, 1, 0);
    run_dump(1'b1, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
